// File: rtl/instr_sequencer.sv
// Program-memory sequencer: fetches instructions, hands them to a coprocessor and shows its result on hex digits.
// Auto-run (run_mode) is available only when SEQ_AUTORUN_EN is defined; otherwise the block is single-step only.
module instr_sequencer #(
   parameter int INSTR_W    = 22,
   parameter int DEPTH      = 32,
   parameter int NUM_DIGITS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     step_in,
   input  logic                     run_mode,
   input  logic [$clog2(DEPTH):0]   prog_len,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [INSTR_W-1:0]       prog_data,
   input  logic                     cop_ready,
   output logic [INSTR_W-1:0]       instr_out,
   output logic                     instr_valid,
   output logic [$clog2(DEPTH)-1:0] pc,
   input  logic [4*NUM_DIGITS-1:0]  result_in,
   input  logic                     result_valid,
   output logic [7*NUM_DIGITS-1:0]  seg
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
   localparam logic [AW-1:0] ONE_A   = AW'(1);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [INSTR_W-1:0]      mem [DEPTH];
   logic                    step_q;
   logic                    step_edge;
   logic                    run_eff;
   logic                    handshake;
   logic                    pc_last;
   logic                    wr_ok;
   logic [AW-1:0]           last_idx;
   logic [4*NUM_DIGITS-1:0] disp;

`ifdef SEQ_AUTORUN_EN
   assign run_eff = run_mode;
`else
   logic unused_run_mode;
   assign unused_run_mode = run_mode;
   assign run_eff         = 1'b0;
`endif

   function automatic logic [6:0] hex7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign step_edge   = step_in & ~step_q;
   assign instr_valid = (state == ISSUE);
   assign handshake   = (state == ISSUE) & cop_ready;
   assign wr_ok       = (state == IDLE) | (state == HALT);
   // A length of 0 or anything beyond the memory runs the whole memory.
   assign last_idx    = ((prog_len == '0) || (prog_len > DEPTH_L)) ? AW'(DEPTH - 1)
                                                                   : AW'(prog_len - ONE_L);
   assign pc_last     = (pc == last_idx);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (step_edge || run_eff) state_nxt = FETCH;
         FETCH: state_nxt = ISSUE;
         ISSUE: begin
            if (cop_ready) begin
               if (run_eff) state_nxt = pc_last ? HALT : FETCH;
               else         state_nxt = IDLE;
            end
         end
         HALT:  if (!run_eff) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FETCH -> ISSUE boundary: instr_out is the registered memory read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= '0;
         instr_out <= '0;
         step_q    <= 1'b0;
         disp      <= '0;
      end else begin
         state  <= state_nxt;
         step_q <= step_in;
         if (state == FETCH) instr_out <= mem[pc];
         if (handshake)      pc        <= pc_last ? '0 : pc + ONE_A;
         if (result_valid)   disp      <= result_in;
      end
   end

   // Program memory is not reset so a mid-run reset keeps the loaded program.
   always_ff @(posedge clk) begin
      if (prog_we && wr_ok) mem[prog_addr] <= prog_data;
   end

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      assign seg[7*k +: 7] = hex7(disp[4*k +: 4]);
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter INSTR_W, default 22, meaning the coprocessor instruction width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning the number of program memory words (power of two).
REQ-003 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of hex display digits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port step_in, input, 1 bit: debounced step button level, active-high.
REQ-007 The block SHALL have port run_mode, input, 1 bit: 1 selects auto-run, 0 selects single-step.
REQ-008 The block SHALL have port prog_len, input, log2(DEPTH)+1 bits: number of program words to execute; 0 or any value above DEPTH means DEPTH.
REQ-009 The block SHALL have ports prog_we (1 bit), prog_addr (log2(DEPTH) bits) and prog_data (INSTR_W bits), all inputs: program memory write port.
REQ-010 The block SHALL have port cop_ready, input, 1 bit: coprocessor accepts the instruction this cycle.
REQ-011 The block SHALL have port instr_out, output, INSTR_W bits: the instruction presented to the coprocessor.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: instr_out is valid.
REQ-013 The block SHALL have port pc, output, log2(DEPTH) bits: address of the next instruction to fetch.
REQ-014 The block SHALL have ports result_in (4*NUM_DIGITS bits) and result_valid (1 bit), both inputs: coprocessor result and its strobe.
REQ-015 The block SHALL have port seg, output, 7*NUM_DIGITS bits: active-low 7-segment patterns; digit k shows result nibble k and occupies seg[7k+:7].

Function
REQ-016 FSM states: IDLE, FETCH, ISSUE, HALT.
REQ-017 Step edge = step_in & ~step_q, where step_q is step_in registered one cycle; exactly one edge per press.
REQ-018 In IDLE, a step edge or run_mode=1 SHALL move to FETCH.
REQ-019 In FETCH, instr_out SHALL load mem[pc] (synchronous read) and the FSM SHALL move to ISSUE on the next cycle.
REQ-020 In ISSUE, instr_valid SHALL be 1 and instr_out SHALL be held stable until a cycle with cop_ready=1.
REQ-021 Handshake cycle (ISSUE & cop_ready): pc SHALL advance to pc+1, or to 0 when pc = effective prog_len-1.
REQ-022 After handshake: single-step goes to IDLE; run_mode goes to FETCH, or to HALT when the wrapped instruction was the last (pc was prog_len-1).
REQ-023 The issue rate SHALL be at most one instruction per 2 cycles (FETCH+ISSUE); latency from step edge to instr_valid SHALL be 2 cycles.
REQ-024 HALT SHALL keep instr_valid=0 and move to IDLE when run_mode=0.
REQ-025 Changing run_mode while in ISSUE SHALL NOT abort the pending instruction; it applies at the handshake.
REQ-026 Step edges outside IDLE SHALL be ignored and not queued.
REQ-027 Program writes SHALL take effect only in IDLE or HALT and are silently dropped in other states; a write and a step edge in the same IDLE cycle SHALL both be honoured (write first, fetch sees new data).
REQ-028 A result_valid pulse SHALL latch result_in into the display register on that clock edge; seg SHALL decode the register combinationally (hex 0-F).

Reset
REQ-029 With rst=1 at a clock edge: state=IDLE, pc=0, instr_out=0, instr_valid=0, step_q=0, display register=0 (every digit shows 7'b1000000).
REQ-030 Reset mid-ISSUE SHALL drop the instruction without a handshake; program memory contents SHALL be retained.

Configuration
REQ-031 Macro SEQ_AUTORUN_EN: when defined, run_mode behaves as above; when undefined, run_mode SHALL be ignored (treated as 0), HALT is unreachable, and only single-step operates.

Verification
REQ-032 Reset, then write mem[0]=22'h000002, mem[1]=22'h000003, prog_len=2, cop_ready=1, one step edge -> instr_valid high 2 cycles after the edge with instr_out=22'h000002; pc=1.
REQ-033 Single-step with cop_ready held 0 for 5 cycles -> instr_valid and instr_out stable for 5 cycles; pc changes only on the cop_ready=1 cycle.
REQ-034 With SEQ_AUTORUN_EN: run_mode=1, prog_len=3, cop_ready=1 -> instructions 0,1,2 issued on cycles 2,4,6 after entry, then HALT, pc=0; run_mode=0 -> IDLE.
REQ-035 Without SEQ_AUTORUN_EN: run_mode=1 and no step edges -> instr_valid never asserts.
REQ-036 result_in=16'hBEEF with result_valid=1 -> seg digits 3..0 show B,E,E,F next cycle; rst -> all digits show 0.
REQ-037 Assert rst during ISSUE; also prog_we during ISSUE -> instr_valid=0 and pc=0 after rst; the write during ISSUE is absent from memory.
